// File: rtl/fp_mult_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_pipe_if
// Brief    : Operand/result handshake bundle for the pipelined FP multiplier.
// Revision : 1.0
// ============================================================================
interface fp_mult_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       rnd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, A, B, rnd, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, A, B, rnd, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface
`default_nettype wire

// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_pipe
// Brief    : 3-stage IEEE-754 multiplier (unpack / multiply / round+pack).
// Revision : 1.0
// ============================================================================
module fp_mult_pipe #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 23,
    parameter int WIDTH     = 1 + EXP_WIDTH + SIG_WIDTH,
    parameter int BIAS      = 2**(EXP_WIDTH-1) - 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fp_mult_pipe_if.slave bus
);
    localparam int c_PW  = 2*SIG_WIDTH + 2;
    localparam int c_EW2 = EXP_WIDTH + 2;
    localparam logic [EXP_WIDTH-1:0]        c_EXP_ONES = '1;
    localparam logic signed [c_EW2-1:0]     c_BIAS_S   = c_EW2'(BIAS);
    localparam logic signed [c_EW2-1:0]     c_EMAX     = c_EW2'((2**EXP_WIDTH) - 1);
    localparam logic signed [c_EW2-1:0]     c_ONE      = c_EW2'(1);
    localparam logic signed [c_EW2-1:0]     c_ZERO     = '0;
    localparam logic [WIDTH-1:0]            c_QNAN     = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
    localparam logic [WIDTH-2:0]            c_INF_MAG  = {{EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
    localparam logic [WIDTH-2:0]            c_MAX_MAG  = {{(EXP_WIDTH-1){1'b1}}, 1'b0, {SIG_WIDTH{1'b1}}};

    logic w_adv;

    // ---------------- S1: unpack / classify ----------------
    logic [EXP_WIDTH-1:0] w_ea, w_eb;
    logic [SIG_WIDTH-1:0] w_fa, w_fb;
    logic                 w_sign, w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b, w_invalid;
    logic signed [c_EW2-1:0] w_e;
    logic                 w_spec;
    logic [WIDTH-1:0]     w_spec_res;
    logic [3:0]           w_spec_flags;

    assign w_sign   = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
    assign w_ea     = bus.A[WIDTH-2 -: EXP_WIDTH];
    assign w_eb     = bus.B[WIDTH-2 -: EXP_WIDTH];
    assign w_fa     = bus.A[SIG_WIDTH-1:0];
    assign w_fb     = bus.B[SIG_WIDTH-1:0];
    // A zero exponent field covers both true zeros and flushed subnormals.
    assign w_zero_a = (w_ea == '0);
    assign w_zero_b = (w_eb == '0);
    assign w_inf_a  = (w_ea == c_EXP_ONES) && (w_fa == '0);
    assign w_inf_b  = (w_eb == c_EXP_ONES) && (w_fb == '0);
    assign w_nan_a  = (w_ea == c_EXP_ONES) && (w_fa != '0);
    assign w_nan_b  = (w_eb == c_EXP_ONES) && (w_fb != '0);
    assign w_invalid = (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b);
    assign w_e = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - c_BIAS_S;

    always_comb begin
        w_spec       = 1'b0;
        w_spec_res   = '0;
        w_spec_flags = '0;
        if (w_nan_a || w_nan_b || w_invalid) begin
            w_spec       = 1'b1;
            w_spec_res   = c_QNAN;
            w_spec_flags = {w_invalid, 3'b000};
        end else if (w_inf_a || w_inf_b) begin
            w_spec     = 1'b1;
            w_spec_res = {w_sign, c_INF_MAG};
        end else if (w_zero_a || w_zero_b) begin
            w_spec     = 1'b1;
            w_spec_res = {w_sign, {(WIDTH-1){1'b0}}};
        end
    end

    logic                    r_v1, r_sign1, r_spec1;
    logic signed [c_EW2-1:0] r_e1;
    logic [SIG_WIDTH-1:0]    r_fa1, r_fb1;
    logic [1:0]              r_rnd1;
    logic [WIDTH-1:0]        r_spec_res1;
    logic [3:0]              r_spec_flags1;

    // ---------------- S2: significand product ----------------
    logic                    r_v2, r_sign2, r_spec2;
    logic signed [c_EW2-1:0] r_e2;
    logic [c_PW-1:0]         r_p2;
    logic [1:0]              r_rnd2;
    logic [WIDTH-1:0]        r_spec_res2;
    logic [3:0]              r_spec_flags2;

    // ---------------- S3: normalise / round / pack ----------------
    logic                    w_msb, w_g, w_s, w_inc, w_carry, w_to_inf;
    logic [c_PW-2:0]         w_pn;
    logic [SIG_WIDTH-1:0]    w_frac, w_frac_r;
    logic [SIG_WIDTH+1:0]    w_mant;
    logic signed [c_EW2-1:0] w_en, w_ef;
    logic [WIDTH-1:0]        w_res;
    logic [3:0]              w_flg;

    assign w_msb  = r_p2[c_PW-1];
    // Hidden bit is dropped; after this the leading one sits just above w_frac.
    assign w_pn   = w_msb ? r_p2[c_PW-2:0] : {r_p2[c_PW-3:0], 1'b0};
    assign w_frac = w_pn[c_PW-2 -: SIG_WIDTH];
    assign w_g    = w_pn[SIG_WIDTH];
    assign w_s    = |w_pn[SIG_WIDTH-1:0];
    assign w_en   = w_msb ? (r_e2 + c_ONE) : r_e2;

    always_comb begin
        w_inc = 1'b0;
        case (r_rnd2)
            2'b00:   w_inc = w_g & (w_s | w_frac[0]);
            2'b01:   w_inc = 1'b0;
            2'b10:   w_inc = ~r_sign2 & (w_g | w_s);
            default: w_inc = r_sign2 & (w_g | w_s);
        endcase
    end

    assign w_mant   = {2'b01, w_frac} + (SIG_WIDTH+2)'(w_inc);
    assign w_carry  = w_mant[SIG_WIDTH+1];
    assign w_frac_r = w_carry ? w_mant[SIG_WIDTH:1] : w_mant[SIG_WIDTH-1:0];
    assign w_ef     = w_carry ? (w_en + c_ONE) : w_en;
    assign w_to_inf = (r_rnd2 == 2'b00) || ((r_rnd2 == 2'b10) && !r_sign2) ||
                      ((r_rnd2 == 2'b11) && r_sign2);

    always_comb begin
        w_res = '0;
        w_flg = '0;
        if (r_spec2) begin
            w_res = r_spec_res2;
            w_flg = r_spec_flags2;
        end else if (w_ef >= c_EMAX) begin
            w_res = {r_sign2, (w_to_inf ? c_INF_MAG : c_MAX_MAG)};
            w_flg = 4'b0101;
        end else if (w_ef <= c_ZERO) begin
            w_res = {r_sign2, {(WIDTH-1){1'b0}}};
            w_flg = 4'b0011;
        end else begin
            w_res = {r_sign2, w_ef[EXP_WIDTH-1:0], w_frac_r};
            w_flg = {3'b000, w_g | w_s};
        end
    end

    // ---------------- pipeline registers ----------------
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    assign w_adv         = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1          <= 1'b0;
            r_sign1       <= 1'b0;
            r_spec1       <= 1'b0;
            r_e1          <= '0;
            r_fa1         <= '0;
            r_fb1         <= '0;
            r_rnd1        <= '0;
            r_spec_res1   <= '0;
            r_spec_flags1 <= '0;
            r_v2          <= 1'b0;
            r_sign2       <= 1'b0;
            r_spec2       <= 1'b0;
            r_e2          <= '0;
            r_p2          <= '0;
            r_rnd2        <= '0;
            r_spec_res2   <= '0;
            r_spec_flags2 <= '0;
            r_out_valid   <= 1'b0;
            r_result      <= '0;
            r_flags       <= '0;
        end else if (w_adv) begin
            r_v1          <= bus.in_valid;
            r_sign1       <= w_sign;
            r_spec1       <= w_spec;
            r_e1          <= w_e;
            r_fa1         <= w_fa;
            r_fb1         <= w_fb;
            r_rnd1        <= bus.rnd;
            r_spec_res1   <= w_spec_res;
            r_spec_flags1 <= w_spec_flags;

            r_v2          <= r_v1;
            r_sign2       <= r_sign1;
            r_spec2       <= r_spec1;
            r_e2          <= r_e1;
            r_p2          <= c_PW'({1'b1, r_fa1}) * c_PW'({1'b1, r_fb1});
            r_rnd2        <= r_rnd1;
            r_spec_res2   <= r_spec_res1;
            r_spec_flags2 <= r_spec_flags1;

            // Bubbles leave the visible result/flags untouched.
            r_out_valid   <= r_v2;
            if (r_v2) begin
                r_result <= w_res;
                r_flags  <= w_flg;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mult_pipe
// Brief    : Self-checking bench for fp_mult_pipe (binary32 configuration).
// Revision : 1.0
// ============================================================================
module tb_fp_mult_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fp_mult_pipe_if #(.WIDTH(32)) bus();
    fp_mult_pipe #(.EXP_WIDTH(8), .SIG_WIDTH(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;
    bit          saw_stall = 1'b0;
    logic [35:0] sb[$];

    localparam int c_NV = 17;
    logic [31:0] tv_a [c_NV] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001,
                                 32'h3F800001, 32'h3F800001, 32'h7F800000, 32'hFF800000, 32'h80000000,
                                 32'h00000001, 32'h7F000000, 32'h7F000000, 32'h00800000, 32'h7FC00000,
                                 32'hFF000000, 32'hBF800000};
    logic [31:0] tv_b [c_NV] = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001,
                                 32'h3FC00000, 32'h3FC00000, 32'h00000000, 32'h40000000, 32'h3F800000,
                                 32'h3F800000, 32'h7F000000, 32'h7F000000, 32'h00800000, 32'h3F800000,
                                 32'h7F000000, 32'hC0000000};
    logic [1:0]  tv_m [c_NV] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0,
                                 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0};
    logic [35:0] tv_x [c_NV] = '{{32'h40400000, 4'b0000}, {32'h3F800002, 4'b0001}, {32'h3F800002, 4'b0001},
                                 {32'h3F800003, 4'b0001}, {32'h3F800002, 4'b0001}, {32'h3FC00002, 4'b0001},
                                 {32'h3FC00001, 4'b0001}, {32'h7FC00000, 4'b1000}, {32'hFF800000, 4'b0000},
                                 {32'h80000000, 4'b0000}, {32'h00000000, 4'b0000}, {32'h7F800000, 4'b0101},
                                 {32'h7F7FFFFF, 4'b0101}, {32'h00000000, 4'b0011}, {32'h7FC00000, 4'b0000},
                                 {32'hFF7FFFFF, 4'b0101}, {32'h40000000, 4'b0000}};
    int bp_idx [6] = '{0, 3, 5, 8, 11, 16};

    // Exact-product model: value = P * 2^(E-46), rounded by remainder comparison.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        logic        sign, za, zb, ia, ib, na, nb, inv, inexact, up;
        logic [47:0] p, q, rem, half;
        int          e, sh;
        sign = a[31] ^ b[31];
        za = (a[30:23] == 8'd0);
        zb = (b[30:23] == 8'd0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        inv = (ia && zb) || (za && ib);
        if (na || nb || inv) return {32'h7FC00000, inv, 3'b000};
        if (ia || ib)        return {sign, 8'hFF, 23'd0, 4'b0000};
        if (za || zb)        return {sign, 31'd0, 4'b0000};
        p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        sh = 23;
        if (p >= (48'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 48'd1 << (sh - 1);
        inexact = (rem != 48'd0);
        case (m)
            2'd0:    up = (rem > half) || ((rem == half) && q[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = inexact && !sign;
            default: up = inexact && sign;
        endcase
        if (up) q = q + 48'd1;
        if (q == (48'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            if (m == 2'd0 || (m == 2'd2 && !sign) || (m == 2'd3 && sign))
                return {sign, 8'hFF, 23'd0, 4'b0101};
            return {sign, 8'hFE, 23'h7FFFFF, 4'b0101};
        end
        if (e <= 0) return {sign, 31'd0, 4'b0011};
        return {sign, 8'(e), q[22:0], 3'b000, inexact};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every cycle the output is valid it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got %h expected none", bus.result);
                end else begin
                    check(bus.out_ready ? "result_xfer" : "result_hold",
                          64'({bus.result, bus.flags}), 64'(sb[0]));
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.A, bus.B, bus.rnd));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        bit ok;
        bus.A = a;
        bus.B = b;
        bus.rnd = m;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (!ok) saw_stall = 1'b1;
            @(posedge clk);
            #1;
            if (ok) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic latency(input int idx);
        int lat;
        send(tv_a[idx], tv_b[idx], tv_m[idx]);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd3);
        drain();
    endtask

    initial begin
        int n0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.A   = '0;
        bus.B   = '0;
        bus.rnd = '0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result",    64'(bus.result),    64'd0);
        check("rst_flags",     64'(bus.flags),     64'd0);
        #21 rst = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < c_NV; i++)
            check($sformatf("model_vec%0d", i), 64'(model(tv_a[i], tv_b[i], tv_m[i])), 64'(tv_x[i]));

        latency(0);

        for (int i = 0; i < c_NV; i++)
            send(tv_a[i], tv_b[i], tv_m[i]);
        drain();

        n0 = n_out;
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(tv_a[bp_idx[i]], tv_b[bp_idx[i]], tv_m[bp_idx[i]]);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    bus.out_ready = !(c >= 2 && c <= 8);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_stall_seen", 64'(saw_stall), 64'd1);
        check("bp_count", 64'(n_out - n0), 64'd6);

        send(tv_a[5], tv_b[5], tv_m[5]);
        send(tv_a[11], tv_b[11], tv_m[11]);
        #2 rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_result",    64'(bus.result),    64'd0);
        check("midrst_flags",     64'(bus.flags),     64'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        latency(16);
        check("post_rst_result", 64'({bus.result, bus.flags}), 64'(tv_x[16]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 binary floating-point multiplier with valid/ready handshake on input and output.
- Supports four rounding modes and full special-case handling (NaN, ±Inf, ±0), and reports exception flags.
- Drop-in successor for the single-cycle FP multiplier in the arithmetic datapath; default parameters give binary32.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- SIG_WIDTH, 23, stored fraction width (hidden bit excluded).
- WIDTH, 1+EXP_WIDTH+SIG_WIDTH, total operand/result width (derived).
- BIAS, 2^(EXP_WIDTH-1)-1, exponent bias (derived).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts operand beat
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- rnd  input  2  rounding mode, sampled with the operands: 00 RNE, 01 RTZ, 10 toward +Inf, 11 toward -Inf
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  packed product
- flags  output  4  {invalid, overflow, underflow, inexact}, aligned with result

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits clear; out_valid=0, result=0, flags=0. in_ready=1 one cycle after release.
- Pipeline advance: adv = !out_valid | out_ready. All stages shift together when adv=1 and hold when adv=0. in_ready = adv (combinational).
- Input transfer: occurs on in_valid & in_ready. Output transfer: occurs on out_valid & out_ready.
- Latency is 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle. Order is preserved; no beat is dropped or duplicated.
- Bubbles propagate as invalid stages. Data in invalid stages is don't-care, but result and flags hold their last value while out_valid=0.
- S1: unpack; sign = sA^sB; classify each operand (zero, subnormal, inf, nan); e = expA+expB-BIAS, signed, width EXP_WIDTH+2; latch rnd.
- S2: P = {1,sigA}*{1,sigB}, width 2*SIG_WIDTH+2.
- S3: normalise, round, then pack.
  - If P MSB=1: e+1 and shift right 1.
  - Guard bit = first bit below the LSB; sticky = OR of remaining bits.
  - Round increment:
    - RNE: g&(s|lsb)
    - RTZ: 0
    - +Inf: !sign&(g|s)
    - -Inf: sign&(g|s)
  - Mantissa carry-out from rounding increments e again.
- Subnormal inputs are flushed to zero of the same sign before classification; they do not set flags.
- Special-case priority, highest first:
  - Any NaN, or Inf×0: result = canonical quiet NaN {0, all-ones exp, 1, zeros}. invalid=1 only for Inf×0.
  - Inf×finite-nonzero, or Inf×Inf: result = Inf with sign; flags=0.
  - Zero operand: result = signed zero; flags=0.
- Overflow, after rounding e ≥ 2^EXP_WIDTH-1: overflow=1, inexact=1.
  - Result is Inf for RNE; Inf for the directed mode toward the sign; otherwise max finite (exp = all-ones minus 1, frac = all-ones).
- Underflow, after rounding e ≤ 0: result = signed zero; underflow=1, inexact=1. No subnormal output is produced.
- Otherwise inexact = g|s.
- rnd changing between beats affects only beats sampled with the new value.

Test Plan:
- RNE, no stall: A=0x3FC00000, B=0x40000000 -> 3 cycles later out_valid=1, result=0x40400000, flags=0000.
- Rounding modes: A=B=0x3F800001 -> RNE/RTZ/-Inf give 0x3F800002; +Inf gives 0x3F800003; inexact=1. Tie case A=0x3F800001, B=0x3FC00000 -> RNE 0x3FC00002, RTZ 0x3FC00001.
- Specials: 0x7F800000×0x00000000 -> 0x7FC00000, flags=1000. 0xFF800000×0x40000000 -> 0xFF800000. 0x80000000×0x3F800000 -> 0x80000000. 0x00000001×0x3F800000 -> 0x00000000.
- Over/underflow: 0x7F000000×0x7F000000 -> RNE 0x7F800000, RTZ 0x7F7FFFFF, flags=0101. 0x00800000×0x00800000 -> 0x00000000, flags=0011.
- Backpressure: stream 6 distinct beats back-to-back with out_ready=0 for cycles 2–8 -> in_ready falls once the pipe fills. All 6 results emerge in order, none lost or duplicated. result is stable while out_valid & !out_ready.
- Reset mid-stream: assert rst=0 with 2 beats in flight -> out_valid=0 immediately (asynchronous), result=0. After release, the first new beat appears with 3-cycle latency.
